// File: rtl/coin_pulse_cond_pkg.sv
// Shared types and widths for the coin pulse conditioner.
// Imported by the per-channel block and the top.
package coin_pulse_cond_pkg;

  typedef enum logic [1:0] {
    CP_IDLE,
    CP_HIGH,
    CP_LOW
  } cp_state_t;

  localparam int FCNT_W = 8;
  localparam int DEBW   = 16;

  // Terminal frame count for a duration given in frames (duration is at least 1).
  function automatic logic [FCNT_W-1:0] last_frame(input int frames);
    return FCNT_W'(frames - 1);
  endfunction

endpackage

// File: rtl/coin_pulse_cond_if.sv
// Coin conditioner bundle: raw buttons and frame timing in, conditioned pulses and queue status out.
interface coin_pulse_cond_if #(
  parameter int NUM_CH = 2,
  parameter int QW     = 3
);

  logic                   vblank;
  logic                   pause;
  logic [NUM_CH-1:0]      coin_in;
  logic [NUM_CH-1:0]      coin_out;
  logic [NUM_CH*QW-1:0]   pending;
  logic [NUM_CH-1:0]      overflow;

  modport master (
    output vblank,
    output pause,
    output coin_in,
    input  coin_out,
    input  pending,
    input  overflow
  );

  modport slave (
    input  vblank,
    input  pause,
    input  coin_in,
    output coin_out,
    output pending,
    output overflow
  );

endinterface

// File: rtl/coin_pulse_chan.sv
// One coin channel: synchroniser, debounce, saturating credit queue and the
// frame-timed HIGH/LOW pulse generator that replays queued credits.
module coin_pulse_chan
  import coin_pulse_cond_pkg::*;
#(
  parameter int DEB_CYCLES   = 16,
  parameter int PULSE_FRAMES = 3,
  parameter int GAP_FRAMES   = 3,
  parameter int QW           = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          tick,
  input  logic          pause,
  input  logic          coin_in,
  output logic          coin_out,
  output logic [QW-1:0] pending,
  output logic          overflow
);

  localparam logic [DEBW-1:0]   DEB_LAST   = DEBW'(DEB_CYCLES - 1);
  localparam logic [FCNT_W-1:0] PULSE_LAST = last_frame(PULSE_FRAMES);
  localparam logic [FCNT_W-1:0] GAP_LAST   = last_frame(GAP_FRAMES);
  localparam logic [QW-1:0]     PEND_MAX   = {QW{1'b1}};

  logic             sync_meta;
  logic             sync;
  logic             stable;
  logic             stable_q;
  logic [DEBW-1:0]  deb_cnt;
  logic             press;

  cp_state_t          state;
  cp_state_t          state_nxt;
  logic [FCNT_W-1:0]  fcnt;
  logic [FCNT_W-1:0]  fcnt_nxt;
  logic               ctick;
  logic               dequeue;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= coin_in;
      sync      <= sync_meta;
    end
  end

  // A new level is accepted only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_cnt  <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      stable_q <= stable;
      if (sync == stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        stable  <= sync;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEBW'(1);
      end
    end
  end

  assign press = stable & ~stable_q;
  assign ctick = tick & ~pause;

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    dequeue   = 1'b0;
    case (state)
      CP_IDLE: begin
        fcnt_nxt = '0;
        if ((pending != '0) && !pause) begin
          state_nxt = CP_HIGH;
          dequeue   = 1'b1;
        end
      end
      CP_HIGH: begin
        if (ctick) begin
          if (fcnt == PULSE_LAST) begin
            state_nxt = CP_LOW;
            fcnt_nxt  = '0;
          end else begin
            fcnt_nxt = fcnt + FCNT_W'(1);
          end
        end
      end
      CP_LOW: begin
        if (ctick) begin
          if (fcnt == GAP_LAST) begin
            state_nxt = CP_IDLE;
            fcnt_nxt  = '0;
          end else begin
            fcnt_nxt = fcnt + FCNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = CP_IDLE;
        fcnt_nxt  = '0;
      end
    endcase
  end

  // coin_out is a flop so the game never sees a combinational path from the inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CP_IDLE;
      fcnt     <= '0;
      coin_out <= 1'b0;
    end else begin
      state    <= state_nxt;
      fcnt     <= fcnt_nxt;
      coin_out <= (state_nxt == CP_HIGH);
    end
  end

  // A simultaneous press and dequeue cancel, so only a lone press can hit the ceiling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= press & ~dequeue & (pending == PEND_MAX);
      if (press && !dequeue) begin
        if (pending != PEND_MAX) begin
          pending <= pending + QW'(1);
        end
      end else if (!press && dequeue) begin
        pending <= pending - QW'(1);
      end
    end
  end

endmodule

// File: rtl/coin_pulse_cond.sv
// Multi-channel coin conditioner: shared vblank frame tick feeding one
// coin_pulse_chan per coin button.
module coin_pulse_cond
  import coin_pulse_cond_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int DEB_CYCLES   = 16,
  parameter int PULSE_FRAMES = 3,
  parameter int GAP_FRAMES   = 3,
  parameter int QW           = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  coin_pulse_cond_if.slave  bus
);

  logic                 vblank_q;
  logic                 tick;
  logic [NUM_CH-1:0]    coin_out_w;
  logic [NUM_CH*QW-1:0] pending_w;
  logic [NUM_CH-1:0]    overflow_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vblank_q <= 1'b0;
    end else begin
      vblank_q <= bus.vblank;
    end
  end

  assign tick = bus.vblank & ~vblank_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    coin_pulse_chan #(
      .DEB_CYCLES   (DEB_CYCLES),
      .PULSE_FRAMES (PULSE_FRAMES),
      .GAP_FRAMES   (GAP_FRAMES),
      .QW           (QW)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (tick),
      .pause    (bus.pause),
      .coin_in  (bus.coin_in[i]),
      .coin_out (coin_out_w[i]),
      .pending  (pending_w[i*QW +: QW]),
      .overflow (overflow_w[i])
    );
  end

  assign bus.coin_out = coin_out_w;
  assign bus.pending  = pending_w;
  assign bus.overflow = overflow_w;

endmodule

// File: tb/tb_coin_pulse_cond.sv
// Self-checking bench for coin_pulse_cond: frame-level credit model compared
// every cycle, plus hand-computed timing and count expectations.
module tb_coin_pulse_cond;

  localparam int NUM_CH    = 2;
  localparam int DEB       = 16;
  localparam int PULSE     = 3;
  localparam int GAP       = 3;
  localparam int QW        = 3;
  localparam int PMAX      = (1 << QW) - 1;
  localparam int VB_PERIOD = 100;
  localparam int VB_HIGH   = 10;
  localparam int ST_WAIT   = 0;
  localparam int ST_PULSE  = 1;
  localparam int ST_GAP    = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  coin_pulse_cond_if #(.NUM_CH(NUM_CH), .QW(QW)) bus ();

  coin_pulse_cond #(
    .NUM_CH       (NUM_CH),
    .DEB_CYCLES   (DEB),
    .PULSE_FRAMES (PULSE),
    .GAP_FRAMES   (GAP),
    .QW           (QW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 1'b0;
  int rise_cnt[NUM_CH];
  int ovf_cnt[NUM_CH];
  bit prev_out[NUM_CH];

  // Model state: sampled button history, accepted level, credits and pulse phase.
  int m_s1[NUM_CH];
  int m_s2[NUM_CH];
  int m_stable[NUM_CH];
  int m_stable_d[NUM_CH];
  int m_run[NUM_CH];
  int m_pend[NUM_CH];
  int m_phase[NUM_CH];
  int m_frames[NUM_CH];
  int m_ovf[NUM_CH];
  int m_vb_prev;

  function automatic int pend(input int ch);
    return int'(bus.pending[ch*QW +: QW]);
  endfunction

  task automatic checkOutput(input string name, input int ch, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL %s ch%0d: got %0d, expected %0d at %0t", name, ch, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int ch, input int hi_cycles, input int lo_cycles);
    bus.coin_in[ch] = 1'b1;
    repeat (hi_cycles) @(negedge clk);
    bus.coin_in[ch] = 1'b0;
    repeat (lo_cycles) @(negedge clk);
  endtask

  task automatic modelStep(input int c, input bit frame, input bit hold, input bit raw);
    bit press;
    bit take;
    press = (m_stable[c] == 1) && (m_stable_d[c] == 0);
    take  = (m_phase[c] == ST_WAIT) && (m_pend[c] > 0) && !hold;
    m_ovf[c]  = (press && !take && (m_pend[c] == PMAX)) ? 1 : 0;
    m_pend[c] = m_pend[c] + int'(press) - int'(take);
    if (m_pend[c] > PMAX) m_pend[c] = PMAX;
    m_stable_d[c] = m_stable[c];
    if (m_s2[c] != m_stable[c]) m_run[c]++;
    else m_run[c] = 0;
    if (m_run[c] == DEB) begin
      m_stable[c] = m_s2[c];
      m_run[c]    = 0;
    end
    m_s2[c] = m_s1[c];
    m_s1[c] = int'(raw);
    case (m_phase[c])
      ST_WAIT: if (take) begin
        m_phase[c]  = ST_PULSE;
        m_frames[c] = 0;
      end
      ST_PULSE: if (frame) begin
        m_frames[c]++;
        if (m_frames[c] == PULSE) begin
          m_phase[c]  = ST_GAP;
          m_frames[c] = 0;
        end
      end
      default: if (frame) begin
        m_frames[c]++;
        if (m_frames[c] == GAP) begin
          m_phase[c]  = ST_WAIT;
          m_frames[c] = 0;
        end
      end
    endcase
  endtask

  task automatic modelLoop();
    bit frame;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int c = 0; c < NUM_CH; c++) begin
          m_s1[c] = 0; m_s2[c] = 0; m_stable[c] = 0; m_stable_d[c] = 0; m_run[c] = 0;
          m_pend[c] = 0; m_phase[c] = ST_WAIT; m_frames[c] = 0; m_ovf[c] = 0;
        end
        m_vb_prev = 0;
      end else begin
        frame = bus.vblank && (m_vb_prev == 0) && !bus.pause;
        for (int c = 0; c < NUM_CH; c++) modelStep(c, frame, bus.pause, bus.coin_in[c]);
        m_vb_prev = int'(bus.vblank);
      end
    end
  endtask

  task automatic compareLoop();
    forever begin
      @(negedge clk);
      if (checking) begin
        for (int c = 0; c < NUM_CH; c++) begin
          checkOutput("coin_out", c, bus.coin_out[c], m_phase[c] == ST_PULSE);
          checkOutput("pending", c, pend(c), m_pend[c]);
          checkOutput("overflow", c, bus.overflow[c], m_ovf[c]);
          if (bus.coin_out[c] && !prev_out[c]) rise_cnt[c]++;
          if (bus.overflow[c]) ovf_cnt[c]++;
          prev_out[c] = bus.coin_out[c];
        end
      end
    end
  endtask

  task automatic waitRises(input int ch, input int target, input int budget, input string name);
    for (int n = 0; n < budget && rise_cnt[ch] < target; n++) @(negedge clk);
    checkOutput(name, ch, rise_cnt[ch], target);
  endtask

  task automatic waitIdle(input int ch, input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      done = !bus.coin_out[ch] && (pend(ch) == 0);
    end
    checkOutput(name, ch, done, 1);
    repeat (GAP * VB_PERIOD + 20) @(negedge clk);
  endtask

  task automatic runTests();
    int hi;
    int base_r0;
    int base_r1;
    int base_o0;
    int base_o1;
    int low_run;
    int min_gap;
    int max_gap;

    #1 reset_n = 1'b0;
    checking = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_coin_out", 0, bus.coin_out, 0);
    checkOutput("rst_pending", 0, bus.pending, 0);
    checkOutput("rst_overflow", 0, bus.overflow, 0);
    reset_n = 1'b1;

    $display("[TB] idle for 10 frames");
    repeat (10 * VB_PERIOD) @(negedge clk);
    checkOutput("idle_coin_out", 0, bus.coin_out, 0);
    checkOutput("idle_pending", 0, bus.pending, 0);
    checkOutput("idle_rises", 0, rise_cnt[0] + rise_cnt[1], 0);

    $display("[TB] single clean press");
    bus.coin_in[0] = 1'b1;
    for (int e = 1; e <= DEB + 4; e++) begin
      @(posedge clk);
      #1;
      if (e == DEB + 3) begin
        checkOutput("press_pending_up", 0, pend(0), 1);
        checkOutput("press_out_not_yet", 0, bus.coin_out[0], 0);
      end
      if (e == DEB + 4) begin
        checkOutput("press_out_rise", 0, bus.coin_out[0], 1);
        checkOutput("press_pending_down", 0, pend(0), 0);
      end
    end
    @(negedge clk);
    hi = 0;
    for (int n = 0; n < 4 * VB_PERIOD && bus.coin_out[0]; n++) begin
      if (n == 10) bus.coin_in[0] = 1'b0;
      hi++;
      @(negedge clk);
    end
    bus.coin_in[0] = 1'b0;
    checkOutput("press_high_len", 0, (hi > (PULSE - 1) * VB_PERIOD) && (hi <= PULSE * VB_PERIOD), 1);
    waitIdle(0, VB_PERIOD, "press_drain");
    checkOutput("press_one_pulse", 0, rise_cnt[0], 1);

    $display("[TB] glitch shorter than debounce");
    base_r0 = rise_cnt[0];
    applyStimulus(0, DEB - 1, 4 * DEB);
    checkOutput("glitch_pending", 0, pend(0), 0);
    checkOutput("glitch_no_pulse", 0, rise_cnt[0] - base_r0, 0);

    $display("[TB] burst of 9 presses on ch0");
    base_r0 = rise_cnt[0];
    base_r1 = rise_cnt[1];
    base_o0 = ovf_cnt[0];
    base_o1 = ovf_cnt[1];
    for (int k = 0; k < 9; k++) applyStimulus(0, 20, 20);
    checkOutput("burst_pending_sat", 0, pend(0), PMAX);
    checkOutput("burst_one_overflow", 0, ovf_cnt[0] - base_o0, 1);
    low_run = 0;
    min_gap = 1000000;
    max_gap = 0;
    for (int n = 0; n < 8000 && !((rise_cnt[0] - base_r0 == 8) && !bus.coin_out[0]); n++) begin
      @(negedge clk);
      if (!bus.coin_out[0]) begin
        low_run++;
      end else begin
        if (low_run > 0) begin
          if (low_run < min_gap) min_gap = low_run;
          if (low_run > max_gap) max_gap = low_run;
        end
        low_run = 0;
      end
    end
    checkOutput("burst_pulses", 0, rise_cnt[0] - base_r0, 8);
    checkOutput("burst_gap_min", 0, min_gap >= (GAP - 1) * VB_PERIOD + 2, 1);
    checkOutput("burst_gap_max", 0, max_gap <= GAP * VB_PERIOD + 1, 1);
    waitIdle(0, VB_PERIOD, "burst_drain");
    checkOutput("burst_overflow_total", 0, ovf_cnt[0] - base_o0, 1);
    checkOutput("burst_ch1_pulses", 1, rise_cnt[1] - base_r1, 0);
    checkOutput("burst_ch1_overflow", 1, ovf_cnt[1] - base_o1, 0);
    checkOutput("burst_ch1_pending", 1, pend(1), 0);

    $display("[TB] pause mid-pulse");
    base_r0 = rise_cnt[0];
    applyStimulus(0, 20, 20);
    checkOutput("pause_pre_high", 0, bus.coin_out[0], 1);
    bus.pause = 1'b1;
    applyStimulus(0, 20, 20);
    checkOutput("pause_press_queued", 0, pend(0), 1);
    checkOutput("pause_hold_early", 0, bus.coin_out[0], 1);
    repeat (5 * VB_PERIOD - 40) @(negedge clk);
    checkOutput("pause_hold_late", 0, bus.coin_out[0], 1);
    checkOutput("pause_no_dequeue", 0, pend(0), 1);
    bus.pause = 1'b0;
    waitRises(0, base_r0 + 2, 1500, "pause_second_pulse");
    waitIdle(0, 1000, "pause_drain");

    $display("[TB] async reset mid-pulse");
    base_r0 = rise_cnt[0];
    for (int k = 0; k < 3; k++) applyStimulus(0, 20, 20);
    checkOutput("rstmid_high", 0, bus.coin_out[0], 1);
    checkOutput("rstmid_pending", 0, pend(0), 2);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rstmid_out_drop", 0, bus.coin_out[0], 0);
    checkOutput("rstmid_pend_clear", 0, pend(0), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (8 * VB_PERIOD) @(negedge clk);
    checkOutput("rstmid_no_pulses", 0, rise_cnt[0] - base_r0, 1);
    checkOutput("rstmid_pend_after", 0, pend(0), 0);
  endtask

  initial begin
    bus.vblank = 1'b0;
    forever begin
      repeat (VB_PERIOD - VB_HIGH) @(negedge clk);
      bus.vblank = 1'b1;
      repeat (VB_HIGH) @(negedge clk);
      bus.vblank = 1'b0;
    end
  end

  initial begin
    bus.coin_in = '0;
    bus.pause   = 1'b0;
    fork
      modelLoop();
      compareLoop();
      runTests();
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
